ufifo_txdrain: RTL and testbench

//  Sequences the transmit path: drains bytes from a ufifo into a UART

---
 rtl/ufifo_txdrain.sv | 91 +++++++++
 tb/tb_ufifo_txdrain.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufifo_txdrain.sv
// Transmit-path sequencer: moves one byte at a time from the TX ufifo into the
// UART transmitter, gated by enable and optional CTS flow control.
module ufifo_txdrain #(
  parameter int BW    = 8,
  parameter int LGCNT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_hw_flow,
  input  logic             i_cts_n,
  input  logic             i_fifo_empty_n,
  input  logic [BW-1:0]    i_fifo_data,
  output logic             o_fifo_rd,
  output logic             o_tx_wr,
  output logic [BW-1:0]    o_tx_data,
  input  logic             i_tx_busy,
  output logic             o_busy,
  output logic [LGCNT-1:0] o_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   cts_meta;
  logic   cts_s;
  logic   cts_ok;
  logic   start;

  // CTS is an asynchronous pin; both stages reset to "not clear".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= i_cts_n;
      cts_s    <= cts_meta;
    end
  end

  always_comb begin
    cts_ok = !i_hw_flow || !cts_s;
    start  = (state == S_IDLE) && i_enable && i_fifo_empty_n && cts_ok && !i_tx_busy;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_fifo_rd <= 1'b0;
      o_tx_wr   <= 1'b0;
      o_tx_data <= '0;
      o_busy    <= 1'b0;
      o_count   <= '0;
    end else begin
      o_fifo_rd <= 1'b0;
      o_tx_wr   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            o_fifo_rd <= 1'b1;
            o_tx_wr   <= 1'b1;
            o_tx_data <= i_fifo_data;
            o_count   <= o_count + LGCNT'(1);
            o_busy    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        // One dead cycle lets the ufifo advance and the transmitter raise busy.
        S_ISSUE: begin
          o_busy <= 1'b1;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_tx_busy) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ufifo_txdrain.sv
// Directed bench for ufifo_txdrain with a queue-based ufifo and busy-counter
// transmitter model; a 4-bit-counter copy checks counter wrap.
module tb_ufifo_txdrain;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       hw = 1'b0;
  logic       cts_n = 1'b1;
  logic       fifo_empty_n = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       tx_busy;
  logic       force_busy = 1'b0;

  logic        fifo_rd, tx_wr, busy;
  logic [7:0]  tx_data;
  logic [15:0] count;
  logic        s_fifo_rd, s_tx_wr, s_busy;
  logic [7:0]  s_tx_data;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  ufifo_txdrain #(.BW(8), .LGCNT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_hw_flow(hw), .i_cts_n(cts_n),
    .i_fifo_empty_n(fifo_empty_n), .i_fifo_data(fifo_data),
    .o_fifo_rd(fifo_rd), .o_tx_wr(tx_wr), .o_tx_data(tx_data),
    .i_tx_busy(tx_busy), .o_busy(busy), .o_count(count)
  );

  ufifo_txdrain #(.BW(8), .LGCNT(4)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_hw_flow(hw), .i_cts_n(cts_n),
    .i_fifo_empty_n(fifo_empty_n), .i_fifo_data(fifo_data),
    .o_fifo_rd(s_fifo_rd), .o_tx_wr(s_tx_wr), .o_tx_data(s_tx_data),
    .i_tx_busy(tx_busy), .o_busy(s_busy), .o_count(s_count)
  );

  // ufifo model
  logic [7:0] fq[$];
  int underflow = 0;

  function automatic void fifo_refresh();
    fifo_empty_n = (fq.size() != 0);
    fifo_data    = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_refresh();
  endtask

  // transmitter model plus write monitor
  int         busy_len = 0;
  int         busy_cnt = 0;
  int         wr_cnt = 0;
  int         strobe_bad = 0;
  int         cyc = 0;
  logic [7:0] wr_q[$];
  int         wr_cyc[$];

  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd !== tx_wr) strobe_bad = strobe_bad + 1;
    if (fifo_rd) begin
      if (fq.size() == 0) underflow = underflow + 1;
      else void'(fq.pop_front());
      fifo_refresh();
    end
    if (tx_wr) begin
      wr_cnt = wr_cnt + 1;
      wr_q.push_back(tx_data);
      wr_cyc.push_back(cyc);
    end
    if (rst)                busy_cnt <= 0;
    else if (tx_wr)         busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fq.delete();
    fifo_refresh();
    wr_q.delete();
    wr_cyc.delete();
    wr_cnt = 0;
  endtask

  // Waits for a visible write strobe; an expired budget is a failed check.
  task automatic wait_wr(input string name, input int budget);
    int n;
    n = 0;
    while (!tx_wr && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, tx_wr}, 32'd1);
  endtask

  typedef struct {
    logic       en;
    logic       hw;
    logic       cts_n;
    logic       fbusy;
    logic       has_byte;
    logic [7:0] data;
    logic       exp_wr;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{en:1'b1, hw:1'b0, cts_n:1'b1, fbusy:1'b0, has_byte:1'b1, data:8'hA1, exp_wr:1'b1};
    vt[1] = '{en:1'b0, hw:1'b0, cts_n:1'b0, fbusy:1'b0, has_byte:1'b1, data:8'hA2, exp_wr:1'b0};
    vt[2] = '{en:1'b1, hw:1'b1, cts_n:1'b1, fbusy:1'b0, has_byte:1'b1, data:8'hA3, exp_wr:1'b0};
    vt[3] = '{en:1'b1, hw:1'b1, cts_n:1'b0, fbusy:1'b0, has_byte:1'b1, data:8'hA4, exp_wr:1'b1};
    vt[4] = '{en:1'b1, hw:1'b0, cts_n:1'b0, fbusy:1'b0, has_byte:1'b1, data:8'hA5, exp_wr:1'b1};
    vt[5] = '{en:1'b1, hw:1'b0, cts_n:1'b0, fbusy:1'b1, has_byte:1'b1, data:8'hA6, exp_wr:1'b0};
    vt[6] = '{en:1'b1, hw:1'b0, cts_n:1'b0, fbusy:1'b0, has_byte:1'b0, data:8'hA7, exp_wr:1'b0};

    rst = 1'b1;
    tick();
    tick();
    check("reset_wr", {31'd0, tx_wr}, 32'd0);
    check("reset_rd", {31'd0, fifo_rd}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", {16'd0, count}, 32'd0);
    check("reset_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Gating table
    busy_len = 0;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      en = 1'b0;
      hw = vt[i].hw;
      cts_n = vt[i].cts_n;
      force_busy = vt[i].fbusy;
      repeat (3) tick();
      if (vt[i].has_byte) push(vt[i].data);
      en = vt[i].en;
      repeat (8) tick();
      check($sformatf("vec%0d_wrcnt", i), wr_cnt, {31'd0, vt[i].exp_wr});
      check($sformatf("vec%0d_count", i), {16'd0, count}, {31'd0, vt[i].exp_wr});
      if (vt[i].exp_wr)
        check($sformatf("vec%0d_data", i), {24'd0, wr_q[0]}, {24'd0, vt[i].data});
      en = 1'b0;
      force_busy = 1'b0;
    end
    hw = 1'b0;
    cts_n = 1'b1;

    // Two bytes, transmitter busy 4 cycles after each write
    do_reset();
    busy_len = 4;
    push(8'h41);
    push(8'h42);
    en = 1'b1;
    repeat (30) tick();
    check("t1_wrcnt", wr_cnt, 32'd2);
    if (wr_q.size() == 2) begin
      check("t1_data0", {24'd0, wr_q[0]}, 32'h41);
      check("t1_data1", {24'd0, wr_q[1]}, 32'h42);
    end else check("t1_qsize", wr_q.size(), 32'd2);
    check("t1_count", {16'd0, count}, 32'd2);
    check("t1_empty", {31'd0, fifo_empty_n}, 32'd0);

    // Empty FIFO for 100 cycles
    do_reset();
    en = 1'b1;
    repeat (100) tick();
    check("t2_wrcnt", wr_cnt, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_count", {16'd0, count}, 32'd0);

    // CTS latency: wr appears on the third edge after the pin drops
    do_reset();
    busy_len = 0;
    hw = 1'b1;
    cts_n = 1'b1;
    en = 1'b1;
    push(8'h55);
    repeat (6) tick();
    check("t3_blocked", wr_cnt, 32'd0);
    cts_n = 1'b0;
    tick();
    check("t3_edge1", {31'd0, tx_wr}, 32'd0);
    tick();
    check("t3_edge2", {31'd0, tx_wr}, 32'd0);
    tick();
    check("t3_edge3", {31'd0, tx_wr}, 32'd1);
    check("t3_data", {24'd0, tx_data}, 32'h55);
    hw = 1'b0;
    cts_n = 1'b1;

    // Enable dropped the cycle after a write; the byte in flight completes
    do_reset();
    busy_len = 10;
    push(8'h61);
    push(8'h62);
    en = 1'b1;
    wait_wr("t4_first_wr", 20);
    tick();
    en = 1'b0;
    repeat (30) tick();
    check("t4_wrcnt", wr_cnt, 32'd1);
    check("t4_count", {16'd0, count}, 32'd1);
    check("t4_busy_done", {31'd0, busy}, 32'd0);
    en = 1'b1;
    repeat (10) tick();
    check("t4_resume", wr_cnt, 32'd2);
    if (wr_q.size() == 2) check("t4_data1", {24'd0, wr_q[1]}, 32'h62);

    // Reset during WAIT, then a back-to-back burst
    do_reset();
    busy_len = 10;
    push(8'h71);
    en = 1'b1;
    wait_wr("t5_wr", 20);
    repeat (3) tick();
    check("t5_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_count", {16'd0, count}, 32'd0);
    check("t5_rst_wr", {31'd0, tx_wr}, 32'd0);
    check("t5_rst_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    fq.delete();
    fifo_refresh();
    wr_q.delete();
    wr_cyc.delete();
    wr_cnt = 0;
    busy_len = 0;
    push(8'h81);
    push(8'h82);
    push(8'h83);
    repeat (20) tick();
    check("t5_wrcnt", wr_cnt, 32'd3);
    if (wr_q.size() == 3) begin
      check("t5_data2", {24'd0, wr_q[2]}, 32'h83);
      check("t5_gap01", wr_cyc[1] - wr_cyc[0], 32'd3);
      check("t5_gap12", wr_cyc[2] - wr_cyc[1], 32'd3);
    end

    // Counter wrap on the 4-bit copy: 15 bytes -> F, one more -> 0
    do_reset();
    busy_len = 0;
    for (int i = 0; i < 15; i++) push(8'(i));
    en = 1'b1;
    repeat (60) tick();
    check("t6_small_max", {28'd0, s_count}, 32'hF);
    check("t6_count15", {16'd0, count}, 32'd15);
    push(8'hEE);
    repeat (8) tick();
    check("t6_small_wrap", {28'd0, s_count}, 32'h0);
    check("t6_count16", {16'd0, count}, 32'd16);

    check("strobes_coincide", strobe_bad, 32'd0);
    check("no_underflow", underflow, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
